// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the switch debounce/latch input stage.
package debounce_pkg;

  localparam int unsigned WIDTH_DEF        = 8;
  localparam int unsigned TICK_DIV_DEF     = 1000;
  localparam int unsigned STABLE_TICKS_DEF = 4;

  localparam int unsigned TICK_DIV_SIM     = 4;
  localparam int unsigned STABLE_TICKS_SIM = 3;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a tick-driven stability counter.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb
);

  localparam int unsigned CW = cnt_width(STABLE_TICKS);

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (i_tick) begin
        // any agreeing tick restarts the disagreement run
        if (r_s2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(STABLE_TICKS - 1)) begin
          r_deb <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/switch_debounce_latch.sv
// Debounced, holdable 8-bit switch word feeding the priority encoder, with change pulse.
module switch_debounce_latch
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw,
  input  logic             hold,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             changed
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = cnt_width(STABLE_TICKS);

  logic [PW-1:0]    r_pre;
  logic [SW-1:0]    r_start;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_changed;
  logic             w_tick;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_data_next;

  assign w_tick = ena && (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (ena) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start <= '0;
      r_valid <= 1'b0;
    end else if (w_tick && !r_valid) begin
      if (r_start == SW'(STABLE_TICKS - 1)) begin
        r_valid <= 1'b1;
      end else begin
        r_start <= r_start + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tick(w_tick),
      .i_raw (raw[g]),
      .o_deb (w_deb[g])
    );
  end

  always_comb begin
    w_data_next = r_data;
    if (!r_valid) begin
      w_data_next = '0;
    end else if (!hold) begin
      w_data_next = w_deb;
    end
  end

  // changed is computed from the same next-value so it coincides with the data update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_data    <= w_data_next;
      r_changed <= (w_data_next != r_data);
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign changed = r_changed;

endmodule

// File: doc/switch_debounce_latch.md
Name: switch_debounce_latch

Overview:
- Input conditioning stage directly upstream of the 8-bit priority encoder / 7-segment decoder.
- Synchronises 8 raw asynchronous switch inputs and debounces each bit independently.
- Optionally freezes the value, then presents a stable 8-bit data word to the encoder's data input.
- Flags every change of the presented word with a one-cycle pulse.

Parameters:
- WIDTH, 8, number of switch bits; the encoder consumes exactly 8.
- TICK_DIV, 1000, clock cycles per debounce sample tick; legal range is 2 or more.
- STABLE_TICKS, 4, consecutive ticks a bit must disagree with its debounced value before it is accepted; legal range is 1 or more.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  block enable; low freezes the prescaler and the debounce counters
- raw  in  WIDTH  asynchronous switch inputs
- hold  in  1  high freezes data; the debounce logic keeps running underneath
- data  out  WIDTH  debounced, held word that feeds the priority encoder
- valid  out  1  high once the startup settle period has completed
- changed  out  1  one-cycle pulse whenever data changes value

Behaviour:
- Reset is synchronous and active-low, sampled on the rising edge of clk. While rst_n=0 at an edge, the following are cleared after that edge:
  - sync flops, prescaler, per-bit counters, debounced state deb
  - data=0, valid=0, changed=0, startup counter
- Synchroniser: two flop stages per bit, raw -> s1 -> s2. All downstream logic sees only s2.
- Prescaler:
  - Counts 0..TICK_DIV-1 while ena=1 and wraps to 0.
  - tick=1 for exactly the one cycle in which the count equals TICK_DIV-1.
  - ena=0: count holds and tick=0.
- Per-bit debounce, updated on tick only. Counter cnt[i] has width clog2(STABLE_TICKS+1).
  - s2[i]==deb[i]: cnt[i] cleared to 0.
  - s2[i]!=deb[i] and cnt[i]==STABLE_TICKS-1: deb[i] takes s2[i] and cnt[i] is cleared to 0.
  - Otherwise: cnt[i] increments.
  - A disagreement must therefore last STABLE_TICKS consecutive ticks. Any agreeing tick restarts the count.
  - Bits are fully independent. Several bits may flip on the same tick.
- Startup:
  - valid rises on the tick that completes STABLE_TICKS ticks after reset. It then stays 1 until the next reset.
  - While valid=0, data is held at 0. deb still tracks the inputs during this time.
- Output register:
  - Each cycle with valid=1 and hold=0, data is loaded from deb, with one cycle of latency.
  - hold=1 keeps data unchanged regardless of deb.
  - On the cycle after hold falls, data is loaded from the current deb.
- changed:
  - Registered, and 1 for exactly the cycle in which data differs from its previous-cycle value.
  - Never asserted while valid=0.
  - Not asserted by reset.
- Latency for a clean raw edge with valid=1 and hold=0 to reach data:
  - Minimum (STABLE_TICKS-1)*TICK_DIV+4 cycles.
  - Maximum STABLE_TICKS*TICK_DIV+3 cycles.
- Simultaneous hold release and deb update on the same edge: data takes the post-update deb one cycle later, as the normal 1-cycle path.
- ena=0 mid-count: the per-bit counters retain their values and resume when ena returns to 1. Sync flops and the output register still operate.
- Reset mid-debounce: all partial counts are discarded. The startup period restarts.

Decomposition:
- Shared package (debounce_pkg) holds:
  - the WIDTH default;
  - a function computing counter width as clog2(n+1);
  - named defaults for TICK_DIV and STABLE_TICKS;
  - the simulation overrides TICK_DIV_SIM=4 and STABLE_TICKS_SIM=3.
- One sub-module, debounce_bit: sync pair, cnt and deb for a single bit. It takes the shared tick as an input. It is instantiated WIDTH times by generate.
- Prescaler, startup counter and output/hold/changed logic live in the top module.

Test Plan (TICK_DIV=4, STABLE_TICKS=3):
- Reset, then raw=0x00 for 20 cycles -> data=0x00 throughout; changed never 1; valid rises within 15 cycles and stays 1.
- After valid, raw=0x80 held steady -> data becomes 0x80 between 12 and 15 cycles after the raw edge; changed is 1 for exactly one cycle; the downstream encoder would show 7.
- Glitch: from data=0x80, raw=0x81 for 6 cycles then back to 0x80 -> data stays 0x80; changed stays 0.
- Hold: hold=1, raw changes 0x80 to 0x01 and stays for 30 cycles -> data stays 0x80. Then hold=0 -> data=0x01 one cycle later, with a single changed pulse.
- ena=0 for 10 cycles inserted mid-debounce of raw=0x00 to 0x0C -> acceptance is delayed by exactly 10 cycles; data ends at 0x0C.
- rst_n=0 for one cycle while data=0x0C and a bit is mid-count -> the next cycle shows data=0x00, valid=0, changed=0; the startup period repeats.
